// File: rtl/unsigned_calc_inv_v.sv
// Sequential inverse of f = 7a - 3b + 6c: recovers a = (F + 3b - 6c) / 7 with a
// bit-serial restoring divider, flagging results no 4-bit unsigned a could produce.
module unsigned_calc_inv_v (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_fu,
    input  logic [3:0] i_bu,
    input  logic [3:0] i_cu,
    output logic [3:0] o_au,
    output logic [2:0] o_rem,
    output logic       o_err,
    output logic       o_valid,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

    state_t     state_q;
    logic [8:0] num_q;
    logic [7:0] dvd_q;
    logic [7:0] quot_q;
    logic [2:0] rem_q;
    logic [2:0] cnt_q;
    logic [3:0] au_q;
    logic [2:0] orem_q;
    logic       err_q;
    logic       valid_q;

    logic [8:0] b_ext;
    logic [8:0] c_ext;
    logic [8:0] num_d;
    logic [3:0] r_shift;
    logic [3:0] r_sub;
    logic       q_bit;
    logic [2:0] rem_d;
    logic [7:0] quot_d;

    // 9-bit two's complement covers -218..172, so the wrap-around sum is exact.
    always_comb begin
        b_ext = {5'b0, i_bu};
        c_ext = {5'b0, i_cu};
        num_d = {i_fu[7], i_fu} + (b_ext << 1) + b_ext - (c_ext << 2) - (c_ext << 1);
    end

    // One restoring step: bring in the dividend MSB, subtract 7 when it fits.
    always_comb begin
        r_shift = {rem_q, dvd_q[7]};
        r_sub   = r_shift - 4'd7;
        q_bit   = (r_shift >= 4'd7);
        rem_d   = q_bit ? r_sub[2:0] : r_shift[2:0];
        quot_d  = (quot_q << 1) | {7'b0, q_bit};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            dvd_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            au_q    <= '0;
            orem_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        num_q   <= num_d;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (num_q[8]) begin
                        err_q   <= 1'b1;
                        au_q    <= '0;
                        orem_q  <= '0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        dvd_q   <= num_q[7:0];
                        rem_q   <= '0;
                        quot_q  <= '0;
                        cnt_q   <= 3'd7;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    dvd_q  <= dvd_q << 1;
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                        if (quot_d > 8'd15) begin
                            err_q  <= 1'b1;
                            au_q   <= '0;
                            orem_q <= '0;
                        end else begin
                            err_q  <= 1'b0;
                            au_q   <= quot_d[3:0];
                            orem_q <= rem_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_au    = au_q;
    assign o_rem   = orem_q;
    assign o_err   = err_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != IDLE);

endmodule
